// File: rtl/sfx_player.sv
// Sound-effect sequencer: watches flap/score/status events from the game controller
// and plays short square-wave note sequences on the buzzer pin.
module sfx_player #(
    parameter int CLK_HZ = 100_000_000,
    parameter int GAP_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        up,
    input  logic [15:0] score,
    input  logic [1:0]  status,
    output logic        audio,
    output logic        busy
);

    localparam int CLK_PER_MS = CLK_HZ / 1000;

    localparam logic [31:0] HP_880  = 32'(CLK_HZ / (2 * 880));
    localparam logic [31:0] HP_988  = 32'(CLK_HZ / (2 * 988));
    localparam logic [31:0] HP_1319 = 32'(CLK_HZ / (2 * 1319));
    localparam logic [31:0] HP_523  = 32'(CLK_HZ / (2 * 523));
    localparam logic [31:0] HP_392  = 32'(CLK_HZ / (2 * 392));
    localparam logic [31:0] HP_262  = 32'(CLK_HZ / (2 * 262));

    localparam logic [31:0] DUR_40  = 32'(40 * CLK_PER_MS);
    localparam logic [31:0] DUR_60  = 32'(60 * CLK_PER_MS);
    localparam logic [31:0] DUR_120 = 32'(120 * CLK_PER_MS);
    localparam logic [31:0] DUR_150 = 32'(150 * CLK_PER_MS);
    localparam logic [31:0] DUR_300 = 32'(300 * CLK_PER_MS);
    localparam logic [31:0] GAP_CLK = 32'(GAP_MS * CLK_PER_MS);

    // Sequence identifiers double as priorities; NONE marks an idle player.
    localparam logic [1:0] PRI_NONE  = 2'd0;
    localparam logic [1:0] PRI_FLAP  = 2'd1;
    localparam logic [1:0] PRI_SCORE = 2'd2;
    localparam logic [1:0] PRI_OVER  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_seq;
    logic [1:0]  r_note;
    logic [31:0] r_hpCnt;
    logic [31:0] r_durCnt;
    logic        r_audio;
    logic        r_upQ;
    logic [15:0] r_scoreQ;
    logic [1:0]  r_statusQ;

    state_t      w_stateNext;
    logic [1:0]  w_seqNext;
    logic [1:0]  w_noteNext;
    logic [31:0] w_hpCntNext;
    logic [31:0] w_durCntNext;
    logic        w_audioNext;

    logic        w_flap;
    logic        w_score;
    logic        w_over;
    logic [1:0]  w_evPri;
    logic        w_take;
    logic        w_statusIdle;
    logic [31:0] w_hp;
    logic [31:0] w_dur;
    logic        w_last;

    assign w_flap       = up & ~r_upQ & (status == 2'b01);
    assign w_score      = score > r_scoreQ;
    assign w_over       = (status == 2'b10) && (r_statusQ != 2'b10);
    assign w_evPri      = w_over ? PRI_OVER : (w_score ? PRI_SCORE : (w_flap ? PRI_FLAP : PRI_NONE));
    assign w_take       = (w_evPri != PRI_NONE) && (w_evPri >= r_seq);
    assign w_statusIdle = (status == 2'b00) || (status == 2'b11);

    always_comb begin
        w_hp   = HP_880;
        w_dur  = DUR_40;
        w_last = 1'b1;
        case (r_seq)
            PRI_SCORE: begin
                if (r_note == 2'd0) begin
                    w_hp   = HP_988;
                    w_dur  = DUR_60;
                    w_last = 1'b0;
                end else begin
                    w_hp   = HP_1319;
                    w_dur  = DUR_120;
                    w_last = 1'b1;
                end
            end
            PRI_OVER: begin
                case (r_note)
                    2'd0: begin
                        w_hp   = HP_523;
                        w_dur  = DUR_150;
                        w_last = 1'b0;
                    end
                    2'd1: begin
                        w_hp   = HP_392;
                        w_dur  = DUR_150;
                        w_last = 1'b0;
                    end
                    default: begin
                        w_hp   = HP_262;
                        w_dur  = DUR_300;
                        w_last = 1'b1;
                    end
                endcase
            end
            default: begin
                w_hp   = HP_880;
                w_dur  = DUR_40;
                w_last = 1'b1;
            end
        endcase
    end

    // Mute beats everything, then a new event, then abort; r_durCnt also times the gap.
    always_comb begin
        w_stateNext  = r_state;
        w_seqNext    = r_seq;
        w_noteNext   = r_note;
        w_hpCntNext  = r_hpCnt;
        w_durCntNext = r_durCnt;
        w_audioNext  = r_audio;
        if (!enable) begin
            w_stateNext  = S_IDLE;
            w_seqNext    = PRI_NONE;
            w_noteNext   = 2'd0;
            w_hpCntNext  = 32'd0;
            w_durCntNext = 32'd0;
            w_audioNext  = 1'b0;
        end else if (w_take) begin
            w_stateNext  = S_PLAY;
            w_seqNext    = w_evPri;
            w_noteNext   = 2'd0;
            w_hpCntNext  = 32'd0;
            w_durCntNext = 32'd0;
            w_audioNext  = 1'b0;
        end else if ((r_state != S_IDLE) && (r_seq != PRI_OVER) && w_statusIdle) begin
            w_stateNext  = S_IDLE;
            w_seqNext    = PRI_NONE;
            w_noteNext   = 2'd0;
            w_hpCntNext  = 32'd0;
            w_durCntNext = 32'd0;
            w_audioNext  = 1'b0;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (r_durCnt == w_dur - 32'd1) begin
                        w_hpCntNext  = 32'd0;
                        w_durCntNext = 32'd0;
                        w_audioNext  = 1'b0;
                        if (w_last) begin
                            w_stateNext = S_IDLE;
                            w_seqNext   = PRI_NONE;
                            w_noteNext  = 2'd0;
                        end else begin
                            w_stateNext = S_GAP;
                        end
                    end else begin
                        w_durCntNext = r_durCnt + 32'd1;
                        if (r_hpCnt == w_hp - 32'd1) begin
                            w_hpCntNext = 32'd0;
                            w_audioNext = ~r_audio;
                        end else begin
                            w_hpCntNext = r_hpCnt + 32'd1;
                        end
                    end
                end
                S_GAP: begin
                    w_audioNext = 1'b0;
                    if (r_durCnt == GAP_CLK - 32'd1) begin
                        w_stateNext  = S_PLAY;
                        w_noteNext   = r_note + 2'd1;
                        w_hpCntNext  = 32'd0;
                        w_durCntNext = 32'd0;
                    end else begin
                        w_durCntNext = r_durCnt + 32'd1;
                    end
                end
                default: begin
                    w_seqNext    = PRI_NONE;
                    w_noteNext   = 2'd0;
                    w_hpCntNext  = 32'd0;
                    w_durCntNext = 32'd0;
                    w_audioNext  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_seq     <= PRI_NONE;
            r_note    <= 2'd0;
            r_hpCnt   <= 32'd0;
            r_durCnt  <= 32'd0;
            r_audio   <= 1'b0;
            r_upQ     <= 1'b0;
            r_scoreQ  <= 16'd0;
            r_statusQ <= 2'b00;
        end else begin
            r_state   <= w_stateNext;
            r_seq     <= w_seqNext;
            r_note    <= w_noteNext;
            r_hpCnt   <= w_hpCntNext;
            r_durCnt  <= w_durCntNext;
            r_audio   <= w_audioNext;
            r_upQ     <= up;
            r_scoreQ  <= score;
            r_statusQ <= status;
        end
    end

    assign audio = r_audio;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player: expected results are queued when stimulus is applied
// and popped as the DUT's audio/busy behaviour is measured.
module tb_sfx_player;

    localparam int CLK_HZ = 50_000;
    localparam int GAP_MS = 10;
    localparam int CPM    = CLK_HZ / 1000;
    localparam int HPF    = CLK_HZ / (2 * 880);
    localparam int HPS1   = CLK_HZ / (2 * 988);
    localparam int HPS2   = CLK_HZ / (2 * 1319);
    localparam int HPO1   = CLK_HZ / (2 * 523);
    localparam int DF     = 40 * CPM;
    localparam int DS1    = 60 * CPM;
    localparam int DS2    = 120 * CPM;
    localparam int DO1    = 150 * CPM;
    localparam int DO2    = 150 * CPM;
    localparam int DO3    = 300 * CPM;
    localparam int GAPC   = GAP_MS * CPM;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        up;
    logic [15:0] score;
    logic [1:0]  status;
    logic        audio;
    logic        busy;

    int          compared;
    int          mismatched;
    string       expTag[$];
    logic [31:0] expVal[$];
    int          n;

    sfx_player #(
        .CLK_HZ(CLK_HZ),
        .GAP_MS(GAP_MS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .up    (up),
        .score (score),
        .status(status),
        .audio (audio),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int cnt);
        for (int i = 0; i < cnt; i++) step();
    endtask

    task automatic applyStimulus(input logic e, input logic u, input logic [15:0] s, input logic [1:0] st);
        enable = e;
        up     = u;
        score  = s;
        status = st;
        step();
    endtask

    task automatic pushExp(input string tag, input int val);
        expTag.push_back(tag);
        expVal.push_back(32'(val));
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        if (expVal.size() == 0) begin
            tag = "no_expectation";
            exp = 32'hDEAD_BEEF;
        end else begin
            tag = expTag.pop_front();
            exp = expVal.pop_front();
        end
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic stepsToAudioChange(input int limit, output int cnt);
        logic prev;
        prev = audio;
        cnt  = 0;
        while (cnt < limit) begin
            step();
            cnt++;
            if (audio !== prev) return;
        end
        cnt = -1;
    endtask

    task automatic stepsToBusyLow(input int limit, output int cnt);
        cnt = 0;
        while (cnt < limit) begin
            step();
            cnt++;
            if (busy === 1'b0) return;
        end
        cnt = -1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst    = 1'b0;
        enable = 1'b0;
        up     = 1'b0;
        score  = 16'd3;
        status = 2'b01;

        pushExp("reset_busy", 0);
        pushExp("reset_audio", 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({31'b0, busy});
        checkOutput({31'b0, audio});
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'd3, 2'b01);
        applyStimulus(1'b0, 1'b0, 16'd3, 2'b01);
        pushExp("no_stale_event", 0);
        applyStimulus(1'b1, 1'b0, 16'd3, 2'b01);
        checkOutput({31'b0, busy});

        $display("[TB] flap sequence");
        pushExp("flap_busy", 1);
        pushExp("flap_first_rise", HPF);
        pushExp("flap_half_period", HPF);
        pushExp("flap_end", DF - 2 * HPF);
        pushExp("flap_end_audio", 0);
        applyStimulus(1'b1, 1'b1, 16'd3, 2'b01);
        checkOutput({31'b0, busy});
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        stepsToBusyLow(5000, n);
        checkOutput(32'(n));
        checkOutput({31'b0, audio});

        $display("[TB] score sequence");
        applyStimulus(1'b1, 1'b0, 16'd3, 2'b01);
        pushExp("score_busy", 1);
        pushExp("score_n1_rise", HPS1);
        pushExp("score_n1_half", HPS1);
        pushExp("score_gap_audio", 0);
        pushExp("score_gap_busy", 1);
        pushExp("score_n2_rise", GAPC + HPS2);
        pushExp("score_n2_half", HPS2);
        pushExp("score_end", DS2 - 2 * HPS2);
        pushExp("score_end_audio", 0);
        applyStimulus(1'b1, 1'b0, 16'd4, 2'b01);
        checkOutput({31'b0, busy});
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        waitCycles(DS1 - 2 * HPS1);
        checkOutput({31'b0, audio});
        checkOutput({31'b0, busy});
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        stepsToBusyLow(20000, n);
        checkOutput(32'(n));
        checkOutput({31'b0, audio});

        $display("[TB] preemption");
        pushExp("pre_score_busy", 1);
        pushExp("pre_flap_dropped_rise", HPS1 - 11);
        pushExp("pre_flap_dropped_half", HPS1);
        pushExp("pre_over_busy", 1);
        pushExp("pre_over_rise", HPO1);
        pushExp("pre_over_half", HPO1);
        pushExp("pre_over_rise2", HPO1);
        pushExp("over_ignores_idle_busy", 1);
        pushExp("over_ignores_idle_audio", 1);
        pushExp("mute_busy", 0);
        pushExp("mute_audio", 0);
        pushExp("reenable_busy", 0);
        applyStimulus(1'b1, 1'b0, 16'd5, 2'b01);
        checkOutput({31'b0, busy});
        waitCycles(10);
        applyStimulus(1'b1, 1'b1, 16'd5, 2'b01);
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        applyStimulus(1'b1, 1'b1, 16'd5, 2'b10);
        checkOutput({31'b0, busy});
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        applyStimulus(1'b1, 1'b1, 16'd5, 2'b00);
        checkOutput({31'b0, busy});
        checkOutput({31'b0, audio});
        applyStimulus(1'b0, 1'b1, 16'd5, 2'b00);
        checkOutput({31'b0, busy});
        checkOutput({31'b0, audio});
        applyStimulus(1'b1, 1'b1, 16'd5, 2'b00);
        checkOutput({31'b0, busy});

        $display("[TB] simultaneous score and over");
        pushExp("sim_busy", 1);
        pushExp("sim_over_rise", HPO1);
        pushExp("sim_over_end", DO1 + GAPC + DO2 + GAPC + DO3 - HPO1);
        pushExp("sim_end_audio", 0);
        applyStimulus(1'b1, 1'b0, 16'd6, 2'b10);
        checkOutput({31'b0, busy});
        stepsToAudioChange(5000, n);
        checkOutput(32'(n));
        stepsToBusyLow(40000, n);
        checkOutput(32'(n));
        checkOutput({31'b0, audio});

        $display("[TB] abort flap and score decrease");
        pushExp("leave_over_no_event", 0);
        pushExp("abort_flap_busy", 1);
        pushExp("abort_busy", 0);
        pushExp("abort_audio", 0);
        pushExp("score_equal_busy", 0);
        pushExp("score_decrease_busy", 0);
        applyStimulus(1'b1, 1'b0, 16'd6, 2'b01);
        checkOutput({31'b0, busy});
        applyStimulus(1'b1, 1'b1, 16'd6, 2'b01);
        checkOutput({31'b0, busy});
        waitCycles(100);
        applyStimulus(1'b1, 1'b1, 16'd6, 2'b00);
        checkOutput({31'b0, busy});
        checkOutput({31'b0, audio});
        applyStimulus(1'b0, 1'b0, 16'd9, 2'b01);
        applyStimulus(1'b1, 1'b0, 16'd9, 2'b01);
        checkOutput({31'b0, busy});
        applyStimulus(1'b1, 1'b0, 16'd0, 2'b01);
        checkOutput({31'b0, busy});

        $display("[TB] asynchronous reset mid-note");
        pushExp("prereset_busy", 1);
        pushExp("prereset_audio", 1);
        pushExp("async_reset_audio", 0);
        pushExp("async_reset_busy", 0);
        pushExp("post_reset_flap_busy", 1);
        applyStimulus(1'b1, 1'b1, 16'd0, 2'b01);
        checkOutput({31'b0, busy});
        waitCycles(HPF + 2);
        checkOutput({31'b0, audio});
        #2;
        rst = 1'b0;
        #1;
        checkOutput({31'b0, audio});
        checkOutput({31'b0, busy});
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'd0, 2'b01);
        checkOutput({31'b0, busy});

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
